// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;

  logic             d_s;
  logic             br_next_s;
  logic             last_s;
  logic             accept_s;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic dbit;
    logic bout;
    dbit = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, dbit};
  endfunction

  // Datapath combinational terms for the current bit position.
  always_comb begin
    d_s       = 1'b0;
    br_next_s = 1'b0;
    {br_next_s, d_s} = full_sub(opa_r[0], opb_r[0], br_r);
    last_s    = (cnt_r == CNT_LAST);
    accept_s  = start_valid & (state_r == IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) state_s = SHIFT;
        else             state_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_s = DONE;
        else        state_s = SHIFT;
      end
      DONE: begin
        if (done_ready) state_s = IDLE;
        else            state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State-decoded status outputs.
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b0;
    case (state_r)
      IDLE:    begin start_ready = 1'b1; busy = 1'b0; end
      SHIFT:   begin start_ready = 1'b0; busy = 1'b1; end
      DONE:    begin start_ready = 1'b0; busy = 1'b1; end
      default: begin start_ready = 1'b0; busy = 1'b0; end
    endcase
  end

  // Operand shifters, borrow, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r      <= {WIDTH{1'b0}};
      opb_r      <= {WIDTH{1'b0}};
      res_r      <= {WIDTH{1'b0}};
      br_r       <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      diff       <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opa_r <= a;
            opb_r <= b;
            br_r  <= 1'b0;
            cnt_r <= {CW{1'b0}};
          end
        end
        SHIFT: begin
          res_r <= {d_s, res_r[WIDTH-1:1]};
          opa_r <= {1'b0, opa_r[WIDTH-1:1]};
          opb_r <= {1'b0, opb_r[WIDTH-1:1]};
          br_r  <= br_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          // The final bit is folded in directly so diff is complete on DONE entry.
          if (last_s) begin
            diff       <= {d_s, res_r[WIDTH-1:1]};
            borrow_out <= br_next_s;
            done_valid <= 1'b1;
          end
        end
        DONE: begin
          if (done_ready) done_valid <= 1'b0;
        end
        default: begin
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=8 cases plus
// back-to-back random streams on WIDTH=8, 2 and 16 instances, scoreboard-checked.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [2:0]  sv;
  logic [2:0]  dr;
  logic [2:0]  sr;
  logic [2:0]  dv;
  logic [2:0]  bo;
  logic [2:0]  bz;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [15:0] d16;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [16:0] sbq[$];

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .done_valid(dv[0]), .done_ready(dr[0]),
    .diff(d8), .borrow_out(bo[0]), .busy(bz[0])
  );

  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .a(a_bus[1:0]), .b(b_bus[1:0]), .done_valid(dv[1]), .done_ready(dr[1]),
    .diff(d2), .borrow_out(bo[1]), .busy(bz[1])
  );

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[2]), .start_ready(sr[2]),
    .a(a_bus), .b(b_bus), .done_valid(dv[2]), .done_ready(dr[2]),
    .diff(d16), .borrow_out(bo[2]), .busy(bz[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] get_diff(input int sel);
    case (sel)
      0:       return {8'd0, d8};
      1:       return {14'd0, d2};
      default: return d16;
    endcase
  endfunction

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input int w);
    logic [15:0] mask;
    logic [15:0] dd;
    mask = 16'((32'd1 << w) - 32'd1);
    dd   = (x - y) & mask;
    return {(x & mask) < (y & mask), dd};
  endfunction

  // One WIDTH=8 operation: accept, wait for result, optional backpressure, handshake.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input int hold, input bit noisy);
    logic [16:0] exp;
    int lat;
    int extra;
    a_bus = {8'd0, ta};
    b_bus = {8'd0, tb};
    sv[0] = 1'b1;
    dr[0] = (hold == 0);
    tick();
    sbq.push_back(model({8'd0, ta}, {8'd0, tb}, 8));
    if (noisy) begin
      a_bus = 16'h00AA;
      b_bus = 16'h0055;
    end else begin
      sv[0] = 1'b0;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (dv[0] !== 1'b1 && lat < 20);
    check("latency", lat, 8);
    exp = (sbq.size() > 0) ? sbq.pop_front() : 17'h1FFFF;
    check("diff", {24'd0, d8}, {24'd0, exp[7:0]});
    check("borrow", {31'd0, bo[0]}, {31'd0, exp[16]});
    check("start_ready_in_done", {31'd0, sr[0]}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", {31'd0, dv[0]}, 32'd1);
      check("bp_diff", {24'd0, d8}, {24'd0, exp[7:0]});
      check("bp_borrow", {31'd0, bo[0]}, {31'd0, exp[16]});
      check("bp_start_ready", {31'd0, sr[0]}, 32'd0);
    end
    dr[0] = 1'b1;
    tick();
    sv[0] = 1'b0;
    check("valid_drop", {31'd0, dv[0]}, 32'd0);
    check("idle_ready", {31'd0, sr[0]}, 32'd1);
    check("hold_diff", {24'd0, d8}, {24'd0, exp[7:0]});
    if (noisy) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (dv[0] === 1'b1 || bz[0] === 1'b1) extra++;
      end
      check("single_result", extra, 0);
    end
    dr[0] = 1'b0;
  endtask

  // Back-to-back random stream with start_valid and done_ready held high.
  task automatic stream(input int sel, input int w, input int n);
    logic [16:0] exp;
    int issued;
    int got;
    int cyc;
    int last_t;
    bit acc;
    issued = 0;
    got    = 0;
    cyc    = 0;
    last_t = -1;
    a_bus   = 16'($urandom);
    b_bus   = 16'($urandom);
    sv[sel] = 1'b1;
    dr[sel] = 1'b1;
    while (got < n && cyc < 400) begin
      acc = (sr[sel] === 1'b1) && (issued < n);
      if (acc) sbq.push_back(model(a_bus, b_bus, w));
      tick();
      cyc++;
      if (acc) begin
        issued++;
        a_bus = 16'($urandom);
        b_bus = 16'($urandom);
        if (issued == n) sv[sel] = 1'b0;
      end
      if (dv[sel] === 1'b1) begin
        exp = (sbq.size() > 0) ? sbq.pop_front() : 17'h1FFFF;
        check($sformatf("stream%0d_diff", w), {16'd0, get_diff(sel)}, {16'd0, exp[15:0]});
        check($sformatf("stream%0d_borrow", w), {31'd0, bo[sel]}, {31'd0, exp[16]});
        if (last_t >= 0) check($sformatf("stream%0d_spacing", w), cyc - last_t, w + 2);
        last_t = cyc;
        got++;
      end
    end
    check($sformatf("stream%0d_count", w), got, n);
    sv[sel] = 1'b0;
    dr[sel] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int fired;
    rst_n = 1'b0;
    sv    = 3'b000;
    dr    = 3'b000;
    a_bus = 16'd0;
    b_bus = 16'd0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_start_ready", {31'd0, sr[0]}, 32'd1);
    check("rst_done_valid", {31'd0, dv[0]}, 32'd0);
    check("rst_diff", {24'd0, d8}, 32'd0);
    check("rst_borrow", {31'd0, bo[0]}, 32'd0);
    check("rst_busy", {31'd0, bz[0]}, 32'd0);

    // Abort mid-operation with an asynchronous reset.
    a_bus = 16'h005A;
    b_bus = 16'h0023;
    sv[0] = 1'b1;
    tick();
    sv[0] = 1'b0;
    tick();
    tick();
    tick();
    check("shift_busy", {31'd0, bz[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_start_ready", {31'd0, sr[0]}, 32'd1);
    check("abort_done_valid", {31'd0, dv[0]}, 32'd0);
    check("abort_busy", {31'd0, bz[0]}, 32'd0);
    check("abort_diff", {24'd0, d8}, 32'd0);
    tick();
    rst_n = 1'b1;
    fired = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dv[0] === 1'b1) fired++;
    end
    check("abort_no_result", fired, 0);

    run8(8'h5A, 8'h23, 0, 1'b0);
    run8(8'h10, 8'h20, 0, 1'b0);
    run8(8'h00, 8'h01, 0, 1'b0);
    run8(8'hFF, 8'hFF, 0, 1'b0);
    run8(8'h80, 8'h01, 5, 1'b0);
    run8(8'h0F, 8'h03, 0, 1'b1);

    stream(0, 8, 4);
    stream(1, 2, 4);
    stream(2, 16, 4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
